// File: rtl/dcm_drp_pkg.sv
// Shared types and constants for the DCM DRP sequencer: FSM states, error codes,
// DRP bus widths and the read-modify-write merge rule.
package dcm_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DRDY = 2'b01;
    localparam logic [1:0] ERR_LOCK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_HOLD,
        ST_LOCK_WAIT,
        ST_DONE
    } state_t;

    // Mask bit 1 keeps the bit read back from the DRP, 0 takes the new data.
    function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] old_val,
                                                    input logic [DRP_DW-1:0] new_val,
                                                    input logic [DRP_DW-1:0] mask);
        return (old_val & mask) | (new_val & ~mask);
    endfunction

endpackage

// File: rtl/dcm_drp_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (clock-manager LOCKED).
module sync_2ff (
    input  logic ACLK,
    input  logic ARESET,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/dcm_drp_sequencer.sv
// Turns a latched register-block command into a DRP read or read-modify-write,
// holding the clock manager in reset around writes and waiting for re-lock.
module dcm_drp_sequencer
    import dcm_drp_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int DRDY_TIMEOUT    = 64,
    parameter int LOCK_TIMEOUT    = 1_000_000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    input  logic              cfg_wr,
    input  logic [DRP_AW-1:0] cfg_addr,
    input  logic [DRP_DW-1:0] cfg_data,
    input  logic [DRP_DW-1:0] cfg_mask,
    output logic              sts_busy,
    output logic              sts_done,
    output logic [1:0]        sts_err,
    output logic [DRP_DW-1:0] sts_rdata,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [DRP_AW-1:0] drp_daddr,
    output logic [DRP_DW-1:0] drp_di,
    input  logic [DRP_DW-1:0] drp_do,
    input  logic              drp_drdy,
    output logic              mmcm_rst,
    input  logic              mmcm_locked
);

    localparam int DCW = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
    localparam int LCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int RCW = $clog2(RST_HOLD_CYCLES);
    localparam logic [DCW-1:0] DRDY_LAST = DCW'(DRDY_TIMEOUT - 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_HOLD_CYCLES - 1);

    state_t            state, state_nxt;
    logic              wr_q;
    logic [DRP_AW-1:0] addr_q;
    logic [DRP_DW-1:0] data_q, mask_q;
    logic [DCW-1:0]    drdy_cnt;
    logic [LCW-1:0]    lock_cnt;
    logic [RCW-1:0]    rst_cnt;
    logic [1:0]        err_q;
    logic              locked_sync;
    logic              accept, wait_st, drdy_to, lock_to, hold_exit;

    sync_2ff u_lock_sync (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .async_in (mmcm_locked),
        .sync_out (locked_sync)
    );

    assign accept    = (state == ST_IDLE) && cfg_start;
    assign wait_st   = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
    assign drdy_to   = wait_st && !drp_drdy && (drdy_cnt == DRDY_LAST);
    assign lock_to   = (state == ST_LOCK_WAIT) && !locked_sync && (lock_cnt == LOCK_LAST);
    assign hold_exit = (state == ST_HOLD) && (rst_cnt >= RST_LAST);

    assign drp_den   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign drp_dwe   = (state == ST_WR_REQ);
    assign drp_daddr = drp_den ? addr_q : '0;
    assign drp_di    = drp_dwe ? drp_merge(sts_rdata, data_q, mask_q) : '0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (cfg_start) state_nxt = ST_RD_REQ;
            ST_RD_REQ:    state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (drp_drdy)     state_nxt = wr_q ? ST_WR_REQ : ST_DONE;
                else if (drdy_to) state_nxt = ST_DONE;
            end
            ST_WR_REQ:    state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (drp_drdy)     state_nxt = ST_HOLD;
                else if (drdy_to) state_nxt = ST_DONE;
            end
            ST_HOLD:      if (hold_exit) state_nxt = ST_LOCK_WAIT;
            ST_LOCK_WAIT: if (locked_sync || lock_to) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Status is published on leaving DONE so done/err/busy change together.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            drdy_cnt  <= '0;
            lock_cnt  <= '0;
            rst_cnt   <= '0;
            err_q     <= ERR_NONE;
            sts_busy  <= 1'b0;
            sts_done  <= 1'b0;
            sts_err   <= ERR_NONE;
            sts_rdata <= '0;
            mmcm_rst  <= 1'b0;
        end else begin
            drdy_cnt <= wait_st ? drdy_cnt + 1'b1 : '0;
            lock_cnt <= (state == ST_LOCK_WAIT) ? lock_cnt + 1'b1 : '0;
            if (mmcm_rst && (rst_cnt != RST_LAST)) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            if (accept) begin
                wr_q     <= cfg_wr;
                addr_q   <= cfg_addr;
                data_q   <= cfg_data;
                mask_q   <= cfg_mask;
                rst_cnt  <= '0;
                err_q    <= ERR_NONE;
                sts_busy <= 1'b1;
                sts_done <= 1'b0;
                sts_err  <= ERR_NONE;
                mmcm_rst <= cfg_wr;
            end
            if ((state == ST_RD_WAIT) && drp_drdy) begin
                sts_rdata <= drp_do;
            end
            if (drdy_to) begin
                err_q    <= ERR_DRDY;
                mmcm_rst <= 1'b0;
            end
            if (hold_exit) begin
                mmcm_rst <= 1'b0;
            end
            if (lock_to) begin
                err_q <= ERR_LOCK;
            end
            if (state == ST_DONE) begin
                sts_busy <= 1'b0;
                sts_done <= 1'b1;
                sts_err  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dcm_drp_sequencer.sv
// Self-checking bench for dcm_drp_sequencer: behavioural DRP memory and MMCM lock
// models, bus monitors, and directed plus randomized read / read-modify-write steps.
module tb_dcm_drp_sequencer;

    localparam int RST_HOLD = 16;
    localparam int DRDY_TO  = 64;
    localparam int LOCK_TO  = 100;

    logic        ACLK, ARESET;
    logic        cfg_start, cfg_wr;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data, cfg_mask;
    logic        sts_busy, sts_done;
    logic [1:0]  sts_err;
    logic [15:0] sts_rdata;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic        drp_drdy, resp_drdy, spurious_drdy;
    logic        mmcm_rst, mmcm_locked;

    assign drp_drdy = resp_drdy | spurious_drdy;

    int errors = 0;
    int checks = 0;

    logic [15:0] drp_mem [128];
    int  resp_delay = 1;
    bit  resp_never = 0;
    int  lock_delay = 10;
    bit  lock_never = 0;

    int          cyc_now = 0;
    int          den_count, dwe_count, dwe_bad, den_overlap, rst_cycles;
    int          wr_drdy_cyc, rst_fall_cyc;
    bit          wr_drdy_seen, outstanding;
    logic        rst_prev = 1'b0;
    logic [6:0]  last_rd_addr, last_wr_addr;
    logic [15:0] last_wr_di;

    dcm_drp_sequencer #(
        .RST_HOLD_CYCLES (RST_HOLD),
        .DRDY_TIMEOUT    (DRDY_TO),
        .LOCK_TIMEOUT    (LOCK_TO)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cfg_start   (cfg_start),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_mask    (cfg_mask),
        .sts_busy    (sts_busy),
        .sts_done    (sts_done),
        .sts_err     (sts_err),
        .sts_rdata   (sts_rdata),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc_now++;

    // DRP slave: memory array, DRDY after resp_delay cycles, writes stored on DEN.
    initial begin : drp_model
        logic [6:0] ra;
        logic       rw;
        resp_drdy = 1'b0;
        drp_do    = 16'h0;
        forever begin
            @(posedge ACLK);
            #1;
            resp_drdy = 1'b0;
            if (drp_den && !resp_never) begin
                ra = drp_daddr;
                rw = drp_dwe;
                if (rw) drp_mem[ra] = drp_di;
                repeat (resp_delay) @(posedge ACLK);
                #1;
                drp_do    = drp_mem[ra];
                resp_drdy = 1'b1;
                if (rw) begin
                    wr_drdy_seen = 1'b1;
                    wr_drdy_cyc  = cyc_now;
                end
            end
        end
    end

    // Clock manager: LOCKED drops in reset and returns lock_delay cycles after release.
    initial begin : lock_model
        int lc;
        lc = 0;
        mmcm_locked = 1'b0;
        forever begin
            @(posedge ACLK);
            #2;
            if (mmcm_rst) begin
                mmcm_locked = 1'b0;
                lc = 0;
            end else if (!mmcm_locked && !lock_never) begin
                lc++;
                if (lc >= lock_delay) mmcm_locked = 1'b1;
            end
        end
    end

    always @(negedge ACLK) begin
        if (drp_den) begin
            den_count++;
            if (outstanding) den_overlap++;
            outstanding = 1'b1;
            if (drp_dwe) begin
                dwe_count++;
                last_wr_addr = drp_daddr;
                last_wr_di   = drp_di;
            end else begin
                last_rd_addr = drp_daddr;
            end
        end else if (drp_drdy) begin
            outstanding = 1'b0;
        end
        if (drp_dwe && !drp_den) dwe_bad++;
        if (mmcm_rst) rst_cycles++;
        if (rst_prev && !mmcm_rst) rst_fall_cyc = cyc_now;
        rst_prev = mmcm_rst;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] mergeExpected(input logic [15:0] old_val,
                                                  input logic [15:0] new_val,
                                                  input logic [15:0] mask);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = mask[i] ? old_val[i] : new_val[i];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearCounters();
        den_count    = 0;
        dwe_count    = 0;
        dwe_bad      = 0;
        den_overlap  = 0;
        rst_cycles   = 0;
        wr_drdy_seen = 1'b0;
        wr_drdy_cyc  = 0;
        rst_fall_cyc = 0;
        outstanding  = 1'b0;
    endtask

    task automatic applyStimulus(input logic wr, input logic [6:0] addr,
                                 input logic [15:0] data, input logic [15:0] mask);
        clearCounters();
        @(negedge ACLK);
        cfg_wr    = wr;
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_mask  = mask;
        cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until sts_done; a blown budget is a failure.
    task automatic waitDone(input int budget, output int n);
        n = 0;
        while (!sts_done && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        checkOutput("done_seen", 32'(sts_done), 32'd1);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"},  32'(sts_busy),  32'd0);
        checkOutput({tag, "_done"},  32'(sts_done),  32'd0);
        checkOutput({tag, "_err"},   32'(sts_err),   32'd0);
        checkOutput({tag, "_rdata"}, 32'(sts_rdata), 32'd0);
        checkOutput({tag, "_den"},   32'(drp_den),   32'd0);
        checkOutput({tag, "_dwe"},   32'(drp_dwe),   32'd0);
        checkOutput({tag, "_daddr"}, 32'(drp_daddr), 32'd0);
        checkOutput({tag, "_di"},    32'(drp_di),    32'd0);
        checkOutput({tag, "_rst"},   32'(mmcm_rst),  32'd0);
    endtask

    initial begin : main
        int          n, dly;
        logic [6:0]  a;
        logic [15:0] d, m, old_val, exp_val, exp_rdata;

        ARESET        = 1'b1;
        cfg_start     = 1'b0;
        cfg_wr        = 1'b0;
        cfg_addr      = 7'h0;
        cfg_data      = 16'h0;
        cfg_mask      = 16'h0;
        spurious_drdy = 1'b0;
        for (int i = 0; i < 128; i++) drp_mem[i] = 16'($urandom);
        clearCounters();

        repeat (3) @(negedge ACLK);
        checkIdleZero("reset");
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);

        // Directed read: 0x08 -> 0x1234 after 3 cycles
        drp_mem[8] = 16'h1234;
        resp_delay = 3;
        applyStimulus(1'b0, 7'h08, 16'h0, 16'h0);
        waitDone(200, n);
        checkOutput("rd_latency",  32'(n),            32'(resp_delay + 2));
        checkOutput("rd_rdata",    32'(sts_rdata),    32'h1234);
        checkOutput("rd_err",      32'(sts_err),      32'(2'b00));
        checkOutput("rd_busy",     32'(sts_busy),     32'd0);
        checkOutput("rd_den_cnt",  32'(den_count),    32'd1);
        checkOutput("rd_dwe_cnt",  32'(dwe_count),    32'd0);
        checkOutput("rd_rst_cyc",  32'(rst_cycles),   32'd0);
        checkOutput("rd_addr",     32'(last_rd_addr), 32'h08);

        // Randomized reads
        for (int k = 0; k < 4; k++) begin
            a = 7'($urandom_range(0, 127));
            dly = int'($urandom_range(1, 6));
            resp_delay = dly;
            exp_rdata = drp_mem[a];
            applyStimulus(1'b0, a, 16'($urandom), 16'($urandom));
            waitDone(200, n);
            checkOutput("rrd_latency", 32'(n),         32'(dly + 2));
            checkOutput("rrd_rdata",   32'(sts_rdata), 32'(exp_rdata));
            checkOutput("rrd_err",     32'(sts_err),   32'(2'b00));
            checkOutput("rrd_den_cnt", 32'(den_count), 32'd1);
        end

        // Directed read-modify-write
        a = 7'h10;
        drp_mem[a] = 16'hA5A5;
        resp_delay = 2;
        lock_delay = 10;
        applyStimulus(1'b1, a, 16'h003C, 16'hFF00);
        waitDone(300, n);
        checkOutput("rmw_di",        32'(last_wr_di),   32'h0000A53C);
        checkOutput("rmw_waddr",     32'(last_wr_addr), 32'(a));
        checkOutput("rmw_den_cnt",   32'(den_count),    32'd2);
        checkOutput("rmw_dwe_cnt",   32'(dwe_count),    32'd1);
        checkOutput("rmw_dwe_alone", 32'(dwe_bad),      32'd0);
        checkOutput("rmw_den_ovl",   32'(den_overlap),  32'd0);
        checkOutput("rmw_rst_hold",  32'(rst_cycles >= RST_HOLD), 32'd1);
        checkOutput("rmw_rst_after", 32'(rst_fall_cyc > wr_drdy_cyc && wr_drdy_seen), 32'd1);
        checkOutput("rmw_err",       32'(sts_err),      32'(2'b00));
        checkOutput("rmw_rst_end",   32'(mmcm_rst),     32'd0);
        checkOutput("rmw_busy",      32'(sts_busy),     32'd0);
        checkOutput("rmw_rdata",     32'(sts_rdata),    32'hA5A5);

        // Randomized read-modify-write with read-back
        for (int k = 0; k < 3; k++) begin
            a = 7'($urandom_range(0, 127));
            d = 16'($urandom);
            m = 16'($urandom);
            resp_delay = int'($urandom_range(1, 5));
            old_val = drp_mem[a];
            exp_val = mergeExpected(old_val, d, m);
            applyStimulus(1'b1, a, d, m);
            waitDone(300, n);
            checkOutput("rrmw_di",  32'(last_wr_di), 32'(exp_val));
            checkOutput("rrmw_err", 32'(sts_err),    32'(2'b00));
            applyStimulus(1'b0, a, 16'h0, 16'h0);
            waitDone(200, n);
            checkOutput("rrmw_readback", 32'(sts_rdata), 32'(exp_val));
            exp_rdata = exp_val;
        end

        // Spurious DRDY in IDLE: nothing may move
        @(negedge ACLK);
        spurious_drdy = 1'b1;
        @(negedge ACLK);
        spurious_drdy = 1'b0;
        clearCounters();
        repeat (3) @(negedge ACLK);
        checkOutput("spur_den",   32'(den_count), 32'd0);
        checkOutput("spur_busy",  32'(sts_busy),  32'd0);
        checkOutput("spur_done",  32'(sts_done),  32'd1);
        checkOutput("spur_rdata", 32'(sts_rdata), 32'(exp_rdata));

        // Start pulses while busy must not disturb the latched command
        a = 7'h22;
        d = 16'($urandom);
        m = 16'($urandom);
        old_val = drp_mem[a];
        resp_delay = 4;
        applyStimulus(1'b1, a, d, m);
        cfg_wr    = 1'b0;
        cfg_addr  = 7'h55;
        cfg_data  = ~d;
        cfg_mask  = ~m;
        cfg_start = 1'b1;
        repeat (3) @(negedge ACLK);
        cfg_start = 1'b0;
        waitDone(300, n);
        checkOutput("busy_den_cnt", 32'(den_count),    32'd2);
        checkOutput("busy_raddr",   32'(last_rd_addr), 32'(a));
        checkOutput("busy_waddr",   32'(last_wr_addr), 32'(a));
        checkOutput("busy_di",      32'(last_wr_di),   32'(mergeExpected(old_val, d, m)));
        checkOutput("busy_err",     32'(sts_err),      32'(2'b00));

        // DRDY timeout on a read and on a write
        resp_never = 1'b1;
        applyStimulus(1'b0, 7'h05, 16'h0, 16'h0);
        waitDone(300, n);
        checkOutput("drdy_to_err",    32'(sts_err),   32'(2'b01));
        checkOutput("drdy_to_busy",   32'(sts_busy),  32'd0);
        checkOutput("drdy_to_den",    32'(den_count), 32'd1);
        checkOutput("drdy_to_window", 32'(n >= DRDY_TO && n <= DRDY_TO + 4), 32'd1);
        applyStimulus(1'b1, 7'h06, 16'h1111, 16'h0);
        waitDone(300, n);
        checkOutput("drdy_to_w_err", 32'(sts_err),   32'(2'b01));
        checkOutput("drdy_to_w_rst", 32'(mmcm_rst),  32'd0);
        checkOutput("drdy_to_w_dwe", 32'(dwe_count), 32'd0);
        resp_never = 1'b0;

        // Lock timeout: LOCKED held low after the write
        lock_never = 1'b1;
        resp_delay = 1;
        applyStimulus(1'b1, 7'h30, 16'h00FF, 16'hF0F0);
        waitDone(600, n);
        checkOutput("lock_to_err",  32'(sts_err),  32'(2'b10));
        checkOutput("lock_to_rst",  32'(mmcm_rst), 32'd0);
        checkOutput("lock_to_busy", 32'(sts_busy), 32'd0);
        checkOutput("lock_to_wait",
                    32'((cyc_now - rst_fall_cyc) >= LOCK_TO && (cyc_now - rst_fall_cyc) <= LOCK_TO + 4),
                    32'd1);
        lock_never = 1'b0;
        repeat (15) @(negedge ACLK);

        // Asynchronous reset while holding the clock manager in reset
        resp_delay = 1;
        applyStimulus(1'b1, 7'h40, 16'hBEEF, 16'h0F0F);
        n = 0;
        while (!wr_drdy_seen && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        repeat (3) @(negedge ACLK);
        checkOutput("hold_rst_high", 32'(mmcm_rst), 32'd1);
        #2;
        ARESET = 1'b1;
        #1;
        checkIdleZero("areset");
        @(negedge ACLK);
        ARESET = 1'b0;
        a = 7'h41;
        resp_delay = 2;
        exp_rdata = drp_mem[a];
        applyStimulus(1'b0, a, 16'h0, 16'h0);
        waitDone(200, n);
        checkOutput("post_rst_rdata",   32'(sts_rdata), 32'(exp_rdata));
        checkOutput("post_rst_err",     32'(sts_err),   32'(2'b00));
        checkOutput("post_rst_latency", 32'(n),         32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
